// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file with write-through bypass, load-use hazard
// detection, and a registered ID/EX boundary with flush/stall control.
// A saturating counter tracks how many load-use bubbles were inserted.
module decode_stage_pipelined #(
    parameter int W            = 16,
    parameter int N            = 3,
    parameter int CW           = 14,
    parameter int MEMREAD_BIT  = 4,
    parameter int REGWRITE_BIT = 2,
    parameter int ZERO_REG     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  src,
    input  logic [N-1:0]  dst,
    input  logic          uses_src,
    input  logic          uses_dst,
    input  logic [CW-1:0] ctrl_in,
    input  logic          wb_en,
    input  logic [N-1:0]  wb_addr,
    input  logic [W-1:0]  wb_data,
    input  logic          flush,
    input  logic          ex_stall,
    output logic          id_stall,
    output logic          out_valid,
    output logic [W-1:0]  out_rsrc,
    output logic [W-1:0]  out_rdst,
    output logic [N-1:0]  out_src,
    output logic [N-1:0]  out_dst,
    output logic [CW-1:0] out_ctrl,
    output logic [15:0]   bubble_cnt
);
    localparam int DEPTH = 1 << N;

    logic [W-1:0] regs [DEPTH];
    logic [W-1:0] rsrc;
    logic [W-1:0] rdst;
    logic         hazard;
    logic         bubble;

    // Operand reads: array value, overridden by same-cycle writeback,
    // with the hard-zero register masking even the bypass.
    always_comb begin
        rsrc = regs[src];
        rdst = regs[dst];
        if (wb_en && wb_addr == src) rsrc = wb_data;
        if (wb_en && wb_addr == dst) rdst = wb_data;
        if (ZERO_REG != 0 && src == '0) rsrc = '0;
        if (ZERO_REG != 0 && dst == '0) rdst = '0;
    end

    // Load-use hazard: a valid load in ID/EX whose destination feeds an
    // operand the instruction in IF/ID actually consumes.
    always_comb begin
        hazard = in_valid && out_valid
              && out_ctrl[MEMREAD_BIT] && out_ctrl[REGWRITE_BIT]
              && ((uses_src && out_dst == src) || (uses_dst && out_dst == dst))
              && !(ZERO_REG != 0 && out_dst == '0);
    end

    assign id_stall = (hazard | ex_stall) & ~flush;
    assign bubble   = flush | hazard | ~in_valid;

    // Register file: reset clears every entry; writes to the hard-zero
    // register are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wb_en && !(ZERO_REG != 0 && wb_addr == '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // ID/EX boundary: flush beats ex_stall; ex_stall holds; otherwise a
    // bubble (hazard, flush, or no instruction) or the decoded instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_rsrc  <= '0;
            out_rdst  <= '0;
            out_src   <= '0;
            out_dst   <= '0;
            out_ctrl  <= '0;
        end else if (flush || !ex_stall) begin
            if (bubble) begin
                out_valid <= 1'b0;
                out_rsrc  <= '0;
                out_rdst  <= '0;
                out_src   <= '0;
                out_dst   <= '0;
                out_ctrl  <= '0;
            end else begin
                out_valid <= 1'b1;
                out_rsrc  <= rsrc;
                out_rdst  <= rdst;
                out_src   <= src;
                out_dst   <= dst;
                out_ctrl  <= ctrl_in;
            end
        end
    end

    // Count only bubbles actually inserted for load-use; saturate at max.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!flush && !ex_stall && hazard && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined. Expected ID/EX contents are
// queued when each step is driven and compared after the capturing edge.
// A second instance with the default (no hard-zero) register 0 shares the
// stimulus to contrast register-0 behaviour.
module tb_decode_stage_pipelined;
    localparam logic [13:0] LOAD = 14'h0014; // memRead + regWrite
    localparam logic [13:0] ALU  = 14'h0004; // regWrite only

    typedef struct {
        logic        v;
        logic [15:0] rs;
        logic [15:0] rd;
        logic [2:0]  s;
        logic [2:0]  d;
        logic [13:0] c;
        logic [15:0] bc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, uses_src, uses_dst, wb_en, flush, ex_stall;
    logic [2:0]  src, dst, wb_addr;
    logic [13:0] ctrl_in;
    logic [15:0] wb_data;

    logic        id_stall, out_valid;
    logic [15:0] out_rsrc, out_rdst, bubble_cnt;
    logic [2:0]  out_src, out_dst;
    logic [13:0] out_ctrl;

    logic        z_id_stall, z_out_valid;
    logic [15:0] z_out_rsrc, z_out_rdst, z_bubble_cnt;
    logic [2:0]  z_out_src, z_out_dst;
    logic [13:0] z_out_ctrl;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    decode_stage_pipelined #(.ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src(src), .dst(dst),
        .uses_src(uses_src), .uses_dst(uses_dst), .ctrl_in(ctrl_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .ex_stall(ex_stall), .id_stall(id_stall), .out_valid(out_valid),
        .out_rsrc(out_rsrc), .out_rdst(out_rdst), .out_src(out_src),
        .out_dst(out_dst), .out_ctrl(out_ctrl), .bubble_cnt(bubble_cnt)
    );

    decode_stage_pipelined dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src(src), .dst(dst),
        .uses_src(uses_src), .uses_dst(uses_dst), .ctrl_in(ctrl_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .ex_stall(ex_stall), .id_stall(z_id_stall), .out_valid(z_out_valid),
        .out_rsrc(z_out_rsrc), .out_rdst(z_out_rdst), .out_src(z_out_src),
        .out_dst(z_out_dst), .out_ctrl(z_out_ctrl), .bubble_cnt(z_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [15:0] rs, input logic [15:0] rd,
                                input logic [2:0] s, input logic [2:0] d,
                                input logic [13:0] c, input logic [15:0] bc);
        exp_t e;
        e.v = v; e.rs = rs; e.rd = rd; e.s = s; e.d = d; e.c = c; e.bc = bc;
        return e;
    endfunction

    task automatic drv(input logic iv, input logic [2:0] s, input logic [2:0] d,
                       input logic us, input logic ud, input logic [13:0] c,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic fl, input logic es);
        in_valid = iv; src = s; dst = d; uses_src = us; uses_dst = ud; ctrl_in = c;
        wb_en = we; wb_addr = wa; wb_data = wd; flush = fl; ex_stall = es;
    endtask

    // Check id_stall before the edge, queue the expectation, clock, compare.
    task automatic tick(input string tag, input logic stall_exp, input exp_t e);
        exp_t g;
        #1;
        chk({tag, ".id_stall"}, {31'd0, id_stall}, {31'd0, stall_exp});
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end else begin
            g = q.pop_front();
            chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, g.v});
            chk({tag, ".rsrc"},  {16'd0, out_rsrc},  {16'd0, g.rs});
            chk({tag, ".rdst"},  {16'd0, out_rdst},  {16'd0, g.rd});
            chk({tag, ".src"},   {29'd0, out_src},   {29'd0, g.s});
            chk({tag, ".dst"},   {29'd0, out_dst},   {29'd0, g.d});
            chk({tag, ".ctrl"},  {18'd0, out_ctrl},  {18'd0, g.c});
            chk({tag, ".bcnt"},  {16'd0, bubble_cnt}, {16'd0, g.bc});
        end
    endtask

    initial begin
        exp_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        tick("reset0", 0, z);
        tick("reset1", 0, z);

        // Same-cycle writeback bypass into the captured operand.
        rst = 1'b1;
        drv(1, 3, 1, 1, 0, ALU, 1, 3, 16'hBEEF, 0, 0);
        tick("bypass", 0, mk(1, 16'hBEEF, 0, 3, 1, ALU, 0));
        drv(1, 1, 3, 1, 1, 14'h0100, 0, 0, 0, 0, 0);
        tick("readback", 0, mk(1, 0, 16'hBEEF, 1, 3, 14'h0100, 0));

        // Load-use on src: one bubble, then the instruction issues.
        drv(1, 3, 5, 1, 0, LOAD, 0, 0, 0, 0, 0);
        tick("load1", 0, mk(1, 16'hBEEF, 0, 3, 5, LOAD, 0));
        drv(1, 5, 2, 1, 0, ALU, 0, 0, 0, 0, 0);
        tick("hazard_src", 1, mk(0, 0, 0, 0, 0, 0, 1));
        drv(1, 5, 2, 1, 0, ALU, 1, 5, 16'h5555, 0, 0);
        tick("reissue", 0, mk(1, 16'h5555, 0, 5, 2, ALU, 1));

        // Same address but operand unused: no stall.
        drv(1, 1, 5, 1, 0, LOAD, 0, 0, 0, 0, 0);
        tick("load2", 0, mk(1, 0, 16'h5555, 1, 5, LOAD, 1));
        drv(1, 5, 6, 0, 0, ALU, 0, 0, 0, 0, 0);
        tick("no_false_hz", 0, mk(1, 16'h5555, 0, 5, 6, ALU, 1));

        // Load-use through the dst operand.
        drv(1, 1, 4, 1, 0, LOAD, 0, 0, 0, 0, 0);
        tick("load3", 0, mk(1, 0, 0, 1, 4, LOAD, 1));
        drv(1, 2, 4, 1, 1, ALU, 0, 0, 0, 0, 0);
        tick("hazard_dst", 1, mk(0, 0, 0, 0, 0, 0, 2));
        tick("reissue2", 0, mk(1, 0, 0, 2, 4, ALU, 2));

        // ex_stall holds ID/EX for three cycles.
        drv(1, 3, 7, 1, 0, 14'h0200, 0, 0, 0, 0, 1);
        tick("exst0", 1, mk(1, 0, 0, 2, 4, ALU, 2));
        tick("exst1", 1, mk(1, 0, 0, 2, 4, ALU, 2));
        tick("exst2", 1, mk(1, 0, 0, 2, 4, ALU, 2));
        ex_stall = 1'b0;
        tick("exst_rel", 0, mk(1, 16'hBEEF, 0, 3, 7, 14'h0200, 2));

        // Flush beats ex_stall and a pending hazard.
        drv(1, 1, 6, 1, 0, LOAD, 0, 0, 0, 0, 0);
        tick("load4", 0, mk(1, 0, 0, 1, 6, LOAD, 2));
        drv(1, 6, 1, 1, 0, ALU, 0, 0, 0, 1, 1);
        tick("flush", 0, mk(0, 0, 0, 0, 0, 0, 2));
        drv(1, 6, 1, 1, 0, ALU, 0, 0, 0, 0, 0);
        tick("post_flush", 0, mk(1, 0, 0, 6, 1, ALU, 2));
        drv(0, 6, 1, 1, 0, ALU, 0, 0, 0, 0, 0);
        tick("no_valid", 0, mk(0, 0, 0, 0, 0, 0, 2));

        // Hard-zero register: writes dropped, reads (even bypassed) are 0.
        drv(1, 0, 0, 1, 0, LOAD, 1, 0, 16'h1234, 0, 0);
        tick("zero_bypass", 0, mk(1, 0, 0, 0, 0, LOAD, 2));
        chk("z.rsrc_bypass", {16'd0, z_out_rsrc}, 32'h1234);
        drv(1, 0, 3, 1, 0, ALU, 0, 0, 0, 0, 0);
        #1;
        chk("z.id_stall", {31'd0, z_id_stall}, 32'd1);
        tick("zero_nostall", 0, mk(1, 0, 16'hBEEF, 0, 3, ALU, 2));
        chk("z.valid", {31'd0, z_out_valid}, 32'd0);
        chk("z.bcnt", {16'd0, z_bubble_cnt}, 32'd3);

        // Reset during a stall, with a coincident writeback that must lose.
        drv(1, 1, 2, 1, 0, LOAD, 0, 0, 0, 0, 0);
        tick("load5", 0, mk(1, 0, 0, 1, 2, LOAD, 2));
        drv(1, 2, 4, 1, 0, ALU, 1, 4, 16'h7777, 0, 0);
        rst = 1'b0;
        tick("rst_stall", 1, z);
        rst = 1'b1;
        drv(1, 2, 4, 1, 0, ALU, 0, 0, 0, 0, 0);
        tick("after_rst", 0, mk(1, 0, 0, 2, 4, ALU, 0));
        drv(1, 3, 4, 1, 0, ALU, 0, 0, 0, 0, 0);
        tick("rf_cleared", 0, mk(1, 0, 0, 3, 4, ALU, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Parametrised next-generation decode stage. It combines a register file (optional hard-zero register, write-through bypass), load-use hazard detection, and a registered ID/EX pipeline boundary with stall and flush control. It sits between fetch/IF-ID and execute, and takes the control bundle from the existing control unit as an opaque vector. It adds bubble insertion and a saturating bubble counter for performance monitoring.

Parameters:
W, 16, datapath / register width in bits
N, 3, register address width; register file depth is 2^N
CW, 14, control bundle width (MEM+EX+WB signals concatenated)
MEMREAD_BIT, 4, index of memRead within ctrl_in
REGWRITE_BIT, 2, index of regWrite within ctrl_in
ZERO_REG, 0, 1: register 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  IF/ID holds a valid instruction
src  in  N  source register address
dst  in  N  destination register address (also read as second operand)
uses_src  in  1  instruction reads src
uses_dst  in  1  instruction reads dst as an operand
ctrl_in  in  CW  control bundle from control unit
wb_en  in  1  writeback enable (regWrite from WB)
wb_addr  in  N  writeback address
wb_data  in  W  writeback data (WD)
flush  in  1  squash the instruction entering ID/EX (branch taken)
ex_stall  in  1  execute cannot accept; hold ID/EX
id_stall  out  1  combinational: upstream must hold IF/ID
out_valid  out  1  ID/EX valid
out_rsrc  out  W  ID/EX source operand
out_rdst  out  W  ID/EX destination operand
out_src  out  N  ID/EX src address
out_dst  out  N  ID/EX dst address
out_ctrl  out  CW  ID/EX control bundle
bubble_cnt  out  16  saturating count of load-use bubbles

Behaviour:
- Reset (rst=0 at posedge): all 2^N registers set to 0. out_valid, out_rsrc, out_rdst, out_src, out_dst, out_ctrl and bubble_cnt set to 0. Reset overrides every other input.
- Register file write: at posedge when wb_en=1. With ZERO_REG=1 and wb_addr=0, the write is dropped.
- Register file read: combinational for both src and dst.
  - Bypass: if wb_en=1 and wb_addr equals the read address, wb_data is returned (write-through).
  - With ZERO_REG=1, address 0 reads 0, including under bypass.
- Hazard: hazard=1 iff all of the following hold:
  - in_valid=1;
  - out_valid=1, out_ctrl[MEMREAD_BIT]=1 and out_ctrl[REGWRITE_BIT]=1;
  - out_dst matches src with uses_src=1, or matches dst with uses_dst=1;
  - not (ZERO_REG=1 and out_dst=0).
- id_stall = (hazard | ex_stall) & ~flush; it is combinational.
- ID/EX update priority at posedge (rst high):
  1. flush=1: load a bubble (out_valid=0, all data/ctrl/address outputs 0). Flush wins over ex_stall and hazard.
  2. ex_stall=1: hold all ID/EX outputs unchanged. The hazard bubble is deferred, and bubble_cnt does not increment.
  3. hazard=1: load a bubble and increment bubble_cnt (saturates at 16'hFFFF, no wrap). IF/ID holds, so the same instruction re-evaluates next cycle.
  4. in_valid=0: load a bubble; bubble_cnt unchanged.
  5. Otherwise: load out_valid=1, read data, src, dst, ctrl_in.
- Latency: one cycle from an accepted instruction to out_valid. A load-use pair costs exactly one bubble.
- Writeback to the same address in the cycle an instruction is captured: the bypass value is captured, never the stale value.
- Simultaneous wb_en with reset: reset wins and the register stays 0.
- Reset mid-stall: ID/EX cleared and id_stall drops the next cycle, because out_valid=0 removes the hazard.

Test Plan:
- Reset/bypass: rst=0 for 2 cycles, release; wb_en=1, wb_addr=3, wb_data=16'hBEEF with src=3, in_valid=1 in the same cycle → next cycle out_rsrc=16'hBEEF, out_valid=1.
- Load-use: load with ctrl memRead=1, regWrite=1, dst=5 accepted; next instr src=5, uses_src=1 → id_stall=1 for one cycle, one cycle with out_valid=0, bubble_cnt=1; then instr issues with out_src=5.
- No false hazard: same load followed by src=5, uses_src=0 (and uses_dst=0) → id_stall=0, no bubble, bubble_cnt unchanged.
- ex_stall hold: assert ex_stall 3 cycles with a valid instr in ID/EX → outputs unchanged, id_stall=1; deassert → next instr loads on the following edge.
- Flush priority: flush=1 together with ex_stall=1 and a pending hazard → next cycle out_valid=0, out_ctrl=0, bubble_cnt unchanged, id_stall=0 during flush.
- ZERO_REG=1: write 16'h1234 to reg 0, then read src=0 → out_rsrc=0. A load with dst=0 followed by src=0 → no stall.
